// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO register unit: ALU op codes, FSM state
// encoding and counter width.
package hilo_pkg;

    localparam logic [3:0] OP_MULT = 4'h3;
    localparam logic [3:0] OP_DIV  = 4'h4;
    localparam int         CNT_W   = 6;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic is_md_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/hilo_busy_ctr.sv
// Loadable down-counter that times the commit latency of an in-flight
// mult/div. It holds at zero and reports zero with a combinational flag.
module hilo_busy_ctr
    import hilo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: load takes priority over decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register unit downstream of the ALU: captures mult/div results and
// serves mfhi/mflo/mthi/mtlo. Define HILO_MULTICYCLE_EN for delayed commit + stall.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        md_start,
    input  logic [3:0]  md_op,
    input  logic [31:0] alu_lo,
    input  logic [31:0] alu_hi,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        rd_en,
    input  logic        rd_sel,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);

    if ((MUL_CYCLES < 1) || (MUL_CYCLES > 63) ||
        (DIV_CYCLES < 1) || (DIV_CYCLES > 63)) begin : g_bad_cfg
        $error("hilo_unit: MUL_CYCLES/DIV_CYCLES must be in 1..63");
    end

    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_s;
    logic        accept_s;

`ifdef HILO_MULTICYCLE_EN

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t           state_r;
    state_t           state_next_s;
    logic [31:0]      pend_hi_r;
    logic [31:0]      pend_lo_r;
    logic             busy_r;
    logic             ctr_load_s;
    logic             ctr_dec_s;
    logic             ctr_zero_s;
    logic             commit_s;
    logic [CNT_W-1:0] load_val_s;

    assign accept_s   = (state_r == IDLE) && md_start && is_md_op(md_op);
    assign load_val_s = (md_op == OP_MULT) ? MUL_LOAD : DIV_LOAD;

    hilo_busy_ctr u_busy_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load_s),
        .load_val (load_val_s),
        .dec      (ctr_dec_s),
        .zero     (ctr_zero_s)
    );

    // State, busy flag and operand capture at the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            pend_hi_r <= 32'h0000_0000;
            pend_lo_r <= 32'h0000_0000;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == BUSY);
            if (accept_s) begin
                pend_hi_r <= alu_hi;
                pend_lo_r <= alu_lo;
            end else begin
                pend_hi_r <= pend_hi_r;
                pend_lo_r <= pend_lo_r;
            end
        end
    end

    // Next-state and counter/commit control.
    always_comb begin
        state_next_s = state_r;
        ctr_load_s   = 1'b0;
        ctr_dec_s    = 1'b0;
        commit_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    ctr_load_s   = 1'b1;
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (ctr_zero_s) begin
                    commit_s     = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    ctr_dec_s    = 1'b1;
                    state_next_s = BUSY;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Architectural HI/LO: moves only write in IDLE, so they never collide with a commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r <= 32'h0000_0000;
            lo_r <= 32'h0000_0000;
        end else if (commit_s) begin
            hi_r <= pend_hi_r;
            lo_r <= pend_lo_r;
        end else if (state_r == IDLE) begin
            if (mthi) begin
                hi_r <= wdata;
            end
            if (mtlo) begin
                lo_r <= wdata;
            end
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    assign busy_s = busy_r;

`else

    assign accept_s = md_start && is_md_op(md_op);

    // Architectural HI/LO: an accepted ALU result overrides a same-cycle move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r <= 32'h0000_0000;
            lo_r <= 32'h0000_0000;
        end else if (accept_s) begin
            hi_r <= alu_hi;
            lo_r <= alu_lo;
        end else begin
            if (mthi) begin
                hi_r <= wdata;
            end
            if (mtlo) begin
                lo_r <= wdata;
            end
        end
    end

    assign busy_s = 1'b0;

`endif

    assign hi    = hi_r;
    assign lo    = lo_r;
    assign busy  = busy_s;
    assign stall = busy_s & (md_start | mthi | mtlo | rd_en);
    assign rdata = rd_sel ? hi_r : lo_r;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench for hilo_unit; covers the multi-cycle build
// when HILO_MULTICYCLE_EN is defined and the direct-write build otherwise.
module tb_hilo_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        md_start;
    logic [3:0]  md_op;
    logic [31:0] alu_lo;
    logic [31:0] alu_hi;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        rd_en;
    logic        rd_sel;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;

    int tests_run = 0;
    int fails     = 0;

    hilo_unit #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .md_start(md_start), .md_op(md_op),
        .alu_lo(alu_lo), .alu_hi(alu_hi), .mthi(mthi), .mtlo(mtlo),
        .wdata(wdata), .rd_en(rd_en), .rd_sel(rd_sel), .rdata(rdata),
        .hi(hi), .lo(lo), .busy(busy), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        md_start = 1'b0; md_op = 4'h0; alu_lo = 32'h0; alu_hi = 32'h0;
        mthi = 1'b0; mtlo = 1'b0; wdata = 32'h0; rd_en = 1'b0; rd_sel = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        tick(); tick();
        tests_run++; if (hi !== 32'h0)   begin fails++; $display("FAIL reset_hi: got %h want 0", hi); end
        tests_run++; if (lo !== 32'h0)   begin fails++; $display("FAIL reset_lo: got %h want 0", lo); end
        tests_run++; if (busy !== 1'b0)  begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        rd_en = 1'b1;
        #1;
        tests_run++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall); end
        tests_run++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        rd_en = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mt_idle;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
        #1;
        tests_run++; if (stall !== 1'b0) begin fails++; $display("FAIL mt_stall: got %b want 0", stall); end
        tick();
        mthi = 1'b0; mtlo = 1'b0; wdata = 32'h0;
        tests_run++; if (hi !== 32'hA5A5_A5A5) begin fails++; $display("FAIL mt_hi: got %h want a5a5a5a5", hi); end
        tests_run++; if (lo !== 32'hA5A5_A5A5) begin fails++; $display("FAIL mt_lo: got %h want a5a5a5a5", lo); end
    endtask

    task automatic test_invalid_op;
        md_start = 1'b1; md_op = 4'h5; alu_hi = 32'h1111_1111; alu_lo = 32'h2222_2222;
        tick();
        md_start = 1'b0;
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL badop_busy: got %b want 0", busy); end
        tests_run++; if (hi !== 32'hA5A5_A5A5) begin fails++; $display("FAIL badop_hi: got %h want a5a5a5a5", hi); end
        repeat (5) tick();
        tests_run++; if (lo !== 32'hA5A5_A5A5) begin fails++; $display("FAIL badop_lo: got %h want a5a5a5a5", lo); end
    endtask

`ifdef HILO_MULTICYCLE_EN

    task automatic test_mult_latency;
        md_start = 1'b1; md_op = 4'h3; alu_hi = 32'h1; alu_lo = 32'hFFFF_FFFE;
        tick();
        md_start = 1'b0; alu_hi = 32'hDEAD_BEEF; alu_lo = 32'h0BAD_F00D;
        tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL mult_busy_e0: got %b want 1", busy); end
        for (int k = 1; k < 4; k++) begin
            tick();
            tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL mult_busy_e%0d: got %b want 1", k, busy); end
            tests_run++; if (hi !== 32'h0) begin fails++; $display("FAIL mult_early_hi_e%0d: got %h want 0", k, hi); end
        end
        tick();
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL mult_busy_done: got %b want 0", busy); end
        tests_run++; if (hi !== 32'h1) begin fails++; $display("FAIL mult_hi: got %h want 1", hi); end
        tests_run++; if (lo !== 32'hFFFF_FFFE) begin fails++; $display("FAIL mult_lo: got %h want fffffffe", lo); end
    endtask

    task automatic test_div_stall;
        int stall_cnt = 0;
        md_start = 1'b1; md_op = 4'h4; alu_lo = 32'h7; alu_hi = 32'h2;
        tick();
        md_start = 1'b0; alu_lo = 32'h0; alu_hi = 32'h0;
        rd_en = 1'b1; rd_sel = 1'b0;
        #1;
        for (int i = 0; i < 100; i++) begin
            if (!stall) break;
            stall_cnt++;
            tick();
        end
        tests_run++; if (stall_cnt !== 32) begin fails++; $display("FAIL div_stall_cycles: got %0d want 32", stall_cnt); end
        tests_run++; if (rdata !== 32'h7) begin fails++; $display("FAIL div_rdata_lo: got %h want 7", rdata); end
        rd_sel = 1'b1;
        #1;
        tests_run++; if (rdata !== 32'h2) begin fails++; $display("FAIL div_rdata_hi: got %h want 2", rdata); end
        rd_en = 1'b0; rd_sel = 1'b0;
    endtask

    task automatic test_back_to_back;
        int wait_cnt = 0;
        md_start = 1'b1; md_op = 4'h3; alu_hi = 32'h11; alu_lo = 32'h22;
        tick();
        md_op = 4'h4; alu_hi = 32'h33; alu_lo = 32'h44;
        #1;
        tests_run++; if (stall !== 1'b1) begin fails++; $display("FAIL b2b_stall: got %b want 1", stall); end
        tick(); tick(); tick();
        tests_run++; if (stall !== 1'b1) begin fails++; $display("FAIL b2b_stall_late: got %b want 1", stall); end
        tests_run++; if (hi !== 32'hA5A5_A5A5) begin fails++; $display("FAIL b2b_hi_early: got %h want a5a5a5a5", hi); end
        tick();
        tests_run++; if (hi !== 32'h11) begin fails++; $display("FAIL b2b_mult_hi: got %h want 11", hi); end
        tests_run++; if (lo !== 32'h22) begin fails++; $display("FAIL b2b_mult_lo: got %h want 22", lo); end
        tests_run++; if (stall !== 1'b0) begin fails++; $display("FAIL b2b_stall_drop: got %b want 0", stall); end
        tick();
        md_start = 1'b0; alu_hi = 32'hFFFF_0000; alu_lo = 32'h0000_FFFF;
        tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_div_accept: got %b want 1", busy); end
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            wait_cnt++;
            tick();
        end
        tests_run++; if (wait_cnt !== 32) begin fails++; $display("FAIL b2b_div_busy: got %0d want 32", wait_cnt); end
        tests_run++; if (hi !== 32'h33) begin fails++; $display("FAIL b2b_div_hi: got %h want 33", hi); end
        tests_run++; if (lo !== 32'h44) begin fails++; $display("FAIL b2b_div_lo: got %h want 44", lo); end
    endtask

    task automatic test_md_with_mt;
        md_start = 1'b1; md_op = 4'h3; alu_hi = 32'h55; alu_lo = 32'h66;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h77;
        tick();
        md_start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        tests_run++; if (hi !== 32'h77) begin fails++; $display("FAIL mdmt_hi_mt: got %h want 77", hi); end
        tests_run++; if (lo !== 32'h77) begin fails++; $display("FAIL mdmt_lo_mt: got %h want 77", lo); end
        repeat (4) tick();
        tests_run++; if (hi !== 32'h55) begin fails++; $display("FAIL mdmt_hi_commit: got %h want 55", hi); end
        tests_run++; if (lo !== 32'h66) begin fails++; $display("FAIL mdmt_lo_commit: got %h want 66", lo); end
    endtask

    task automatic test_reset_mid;
        md_start = 1'b1; md_op = 4'h4; alu_hi = 32'h99; alu_lo = 32'h88;
        tick();
        md_start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        tests_run++; if (hi !== 32'h0) begin fails++; $display("FAIL rstmid_hi: got %h want 0", hi); end
        tests_run++; if (lo !== 32'h0) begin fails++; $display("FAIL rstmid_lo: got %h want 0", lo); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        rst = 1'b0;
        repeat (40) tick();
        tests_run++; if (hi !== 32'h0) begin fails++; $display("FAIL rstmid_no_commit_hi: got %h want 0", hi); end
        tests_run++; if (lo !== 32'h0) begin fails++; $display("FAIL rstmid_no_commit_lo: got %h want 0", lo); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy_late: got %b want 0", busy); end
    endtask

`else

    task automatic test_direct_mult;
        md_start = 1'b1; md_op = 4'h3; alu_hi = 32'h1; alu_lo = 32'hFFFF_FFFE;
        rd_en = 1'b1; rd_sel = 1'b1;
        #1;
        tests_run++; if (stall !== 1'b0) begin fails++; $display("FAIL direct_stall_accept: got %b want 0", stall); end
        tick();
        md_start = 1'b0; alu_hi = 32'h0; alu_lo = 32'h0;
        #1;
        tests_run++; if (rdata !== 32'h1) begin fails++; $display("FAIL direct_rdata: got %h want 1", rdata); end
        tests_run++; if (lo !== 32'hFFFF_FFFE) begin fails++; $display("FAIL direct_lo: got %h want fffffffe", lo); end
        tests_run++; if (stall !== 1'b0) begin fails++; $display("FAIL direct_stall_read: got %b want 0", stall); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL direct_busy: got %b want 0", busy); end
        rd_en = 1'b0; rd_sel = 1'b0;
    endtask

    task automatic test_md_wins;
        md_start = 1'b1; md_op = 4'h4; alu_hi = 32'h2; alu_lo = 32'h7;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h77;
        tick();
        md_start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        tests_run++; if (hi !== 32'h2) begin fails++; $display("FAIL mdwins_hi: got %h want 2", hi); end
        tests_run++; if (lo !== 32'h7) begin fails++; $display("FAIL mdwins_lo: got %h want 7", lo); end
    endtask

    task automatic test_mthi_only;
        mthi = 1'b1; wdata = 32'h1234;
        tick();
        mthi = 1'b0;
        tests_run++; if (hi !== 32'h1234) begin fails++; $display("FAIL mthi_hi: got %h want 1234", hi); end
        tests_run++; if (lo !== 32'h7) begin fails++; $display("FAIL mthi_lo_kept: got %h want 7", lo); end
        mtlo = 1'b1; wdata = 32'h5678;
        tick();
        mtlo = 1'b0;
        tests_run++; if (lo !== 32'h5678) begin fails++; $display("FAIL mtlo_lo: got %h want 5678", lo); end
        tests_run++; if (hi !== 32'h1234) begin fails++; $display("FAIL mtlo_hi_kept: got %h want 1234", hi); end
    endtask

    task automatic test_reset_mid;
        #2 rst = 1'b1;
        #1;
        tests_run++; if (hi !== 32'h0) begin fails++; $display("FAIL rstmid_hi: got %h want 0", hi); end
        tests_run++; if (lo !== 32'h0) begin fails++; $display("FAIL rstmid_lo: got %h want 0", lo); end
        rst = 1'b0;
        tick();
    endtask

`endif

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
`ifdef HILO_MULTICYCLE_EN
        test_mult_latency();
        test_div_stall();
        test_mt_idle();
        test_invalid_op();
        test_back_to_back();
        test_md_with_mt();
        test_reset_mid();
`else
        test_direct_mult();
        test_mt_idle();
        test_invalid_op();
        test_md_wins();
        test_mthi_only();
        test_reset_mid();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
